// File: rtl/div_pkg.sv
// Shared width, FSM encoding and result constants for the iterative divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUO = '1;
  localparam logic [DIV_WIDTH-1:0] INT_MIN      = {1'b1, {(DIV_WIDTH-1){1'b0}}};

endpackage

// File: rtl/iter_divider_if.sv
// Issue/result bundle between the pipeline (master) and the divider (slave).
interface iter_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder
  );

endinterface

// File: rtl/iter_divider_sub.sv
// Combinational N-bit subtractor; borrow_o=1 when b_i > a_i (unsigned).
module iter_divider_sub
  import div_pkg::*;
#(
  parameter int N = DIV_WIDTH + 1
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         borrow_o
);

  assign {borrow_o, diff_o} = {1'b0, a_i} - {1'b0, b_i};

endmodule

// File: rtl/iter_divider.sv
// Restoring divider, one trial subtraction per clock, RISC-V DIV/DIVU/REM/REMU results.
// Build option DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish on the start edge.
module iter_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  iter_divider_if.slave bus
);

  localparam int               CW        = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] QUO_ONES  = DIV_ZERO_QUO;
  localparam logic [WIDTH-1:0] MIN_VAL   = INT_MIN;
  localparam logic [WIDTH-1:0] ONE_VAL   = WIDTH'(1);

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dnd_q, dnd_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             sgn_q, sgn_d;
  logic             dsign_q, dsign_d;
  logic             vsign_q, vsign_d;

  logic             a_neg, b_neg, in_dz, in_ovf;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   part_rem, trial_diff;
  logic             trial_borrow, unused_diff_msb;
  logic             fix_dz, fix_ovf, fix_qneg, fix_rneg;

  // Magnitudes: INT_MIN negates to itself and is then read as unsigned.
  assign a_neg  = bus.is_signed & bus.dividend[WIDTH-1];
  assign b_neg  = bus.is_signed & bus.divisor[WIDTH-1];
  assign a_mag  = a_neg ? -bus.dividend : bus.dividend;
  assign b_mag  = b_neg ? -bus.divisor : bus.divisor;
  assign in_dz  = (bus.divisor == '0);
  assign in_ovf = bus.is_signed && (bus.dividend == MIN_VAL) && (bus.divisor == QUO_ONES);

  // Partial remainder carries one extra bit so the trial subtraction keeps its borrow.
  assign part_rem = {rem_q, quo_q[WIDTH-1]};

  iter_divider_sub #(.N(WIDTH + 1)) u_sub (
    .a_i      (part_rem),
    .b_i      ({1'b0, dvs_q}),
    .diff_o   (trial_diff),
    .borrow_o (trial_borrow)
  );

  // Without a borrow the difference is below the divisor, so its top bit is always zero.
  assign unused_diff_msb = trial_diff[WIDTH];

  assign fix_dz   = (dvs_q == '0);
  assign fix_ovf  = sgn_q & dsign_q & vsign_q & (dnd_q == MIN_VAL) & (dvs_q == ONE_VAL);
  assign fix_qneg = sgn_q & (dsign_q ^ vsign_q);
  assign fix_rneg = sgn_q & dsign_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    dnd_d   = dnd_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    sgn_d   = sgn_q;
    dsign_d = dsign_q;
    vsign_d = vsign_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          state_d = CALC;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = a_mag;
          dvs_d   = b_mag;
          dnd_d   = bus.dividend;
          sgn_d   = bus.is_signed;
          dsign_d = bus.dividend[WIDTH-1];
          vsign_d = bus.divisor[WIDTH-1];
          if (EARLY_OUT && (in_dz || in_ovf)) begin
            state_d = DONE;
            quot_d  = in_dz ? QUO_ONES : MIN_VAL;
            remo_d  = in_dz ? bus.dividend : '0;
          end
        end
      end

      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (trial_borrow) begin
          rem_d = part_rem[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
          rem_d = trial_diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end
        if (cnt_q == LAST_ITER) begin
          state_d = FIX;
        end
      end

      FIX: begin
        state_d = DONE;
        if (fix_dz) begin
          quot_d = QUO_ONES;
          remo_d = dnd_q;
        end else if (fix_ovf) begin
          quot_d = MIN_VAL;
          remo_d = '0;
        end else begin
          quot_d = fix_qneg ? -quo_q : quo_q;
          remo_d = fix_rneg ? -rem_q : rem_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      dnd_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      sgn_q   <= 1'b0;
      dsign_q <= 1'b0;
      vsign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dnd_q   <= dnd_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      sgn_q   <= sgn_d;
      dsign_q <= dsign_d;
      vsign_q <= vsign_d;
    end
  end

  assign bus.busy      = (state_q == CALC) || (state_q == FIX);
  assign bus.done      = (state_q == DONE);
  assign bus.quotient  = quot_q;
  assign bus.remainder = remo_q;

endmodule
